period_meter: RTL

- Receive end of the clock-divider path: measures the period, in system-clock cycles, of a slow external or divided square wave.
- Typical source is a divider output or an off-chip oscillator pin.
- Each completed period is reported as a count with a valid/ack handshake to downstream logic (display, UART reporter).

---
 rtl/period_meter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/period_meter.sv
// Period meter: measures rising-edge spacing of an asynchronous square wave in clk cycles.
// Optional HIGH_TIME_EN macro adds a high-time measurement sharing the result handshake.
module period_meter #(
  parameter int W           = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         sig_in,
  output logic [W-1:0] period,
  output logic         period_valid,
  input  logic         period_ack,
  output logic         ovf,
  output logic         overrun
`ifdef HIGH_TIME_EN
  ,
  output logic [W-1:0] high_time
`endif
);

  localparam logic [0:0]   IDLE    = 1'b0;
  localparam logic [0:0]   MEASURE = 1'b1;
  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [0:0]             state_q, state_d;
  logic [W-1:0]           cnt_q, cnt_d;
  logic                   sat_q, sat_d;
  logic [W-1:0]           period_q, period_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;
  logic                   overrun_q, overrun_d;

  logic sync_out;
  logic edge_det;
  logic capture;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign edge_det = sync_out & ~hist_q;
  // The edge is judged against the current state, so an edge coinciding with en falling still captures.
  assign capture  = (state_q == MEASURE) && edge_det;

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
    sync_d    = {sync_q[SYNC_STAGES-2:0], sig_in};
    hist_d    = sync_out;
    state_d   = state_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    period_d  = period_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    overrun_d = overrun_q;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else if (state_q == IDLE) begin
      cnt_d = '0;
      sat_d = 1'b0;
      if (edge_det) begin
        state_d = MEASURE;
        cnt_d   = CNT_ONE;
      end
    end else if (edge_det) begin
      cnt_d = CNT_ONE;
      sat_d = 1'b0;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
      if (cnt_d == CNT_MAX) sat_d = 1'b1;
    end

    // Result register: a capture wins over an ack; overrun records only unconsumed overwrites.
    if (capture) begin
      period_d  = cnt_q;
      ovf_d     = sat_q;
      valid_d   = 1'b1;
      overrun_d = valid_q & ~period_ack;
    end else if (valid_q && period_ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (rst) begin
      sync_q    <= '0;
      hist_q    <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      hist_q    <= hist_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      overrun_q <= overrun_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign ovf          = ovf_q;
  assign overrun      = overrun_q;

`ifdef HIGH_TIME_EN
  logic [W-1:0] hcnt_q, hcnt_d;
  logic [W-1:0] high_q, high_d;

  // The edge cycle itself is high, hence the +1 at capture.
  always_comb begin
    hcnt_d = hcnt_q;
    high_d = high_q;
    if (!en || state_q == IDLE || edge_det) begin
      hcnt_d = '0;
    end else if (sync_out && hcnt_q != CNT_MAX) begin
      hcnt_d = hcnt_q + CNT_ONE;
    end
    if (capture) high_d = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
      high_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      high_q <= high_d;
    end
  end

  assign high_time = high_q;
`endif

endmodule
